// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and helpers used by the bus interface and its responders.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  // Only the named encodings are listed; other bit combinations are still legal on the bus.
  typedef enum logic [2:0] {
    PROT_DEFAULT = 3'b000,
    PROT_PRIV    = 3'b001,
    PROT_NONSEC  = 3'b010,
    PROT_INSTR   = 3'b100
  } axil_prot_t;

  // Byte-lane merge sized for the widest supported bus; callers cast to their own width.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_data,
                                             input logic [63:0] new_data,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_data;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_data[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface AXIL_IF #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]  awaddr;
  axil_pkg::axil_prot_t   awprot;
  logic                   awvalid;
  logic                   awready;
  logic [DATA_WIDTH-1:0]  wdata;
  logic [STRB_WIDTH-1:0]  wstrb;
  logic                   wvalid;
  logic                   wready;
  axil_pkg::axil_resp_t   bresp;
  logic                   bvalid;
  logic                   bready;
  logic [ADDR_WIDTH-1:0]  araddr;
  axil_pkg::axil_prot_t   arprot;
  logic                   arvalid;
  logic                   arready;
  logic [DATA_WIDTH-1:0]  rdata;
  axil_pkg::axil_resp_t   rresp;
  logic                   rvalid;
  logic                   rready;

  modport Master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite control-register bank: independent AW/W capture, byte-strobed writes,
// one-cycle read latency, SLVERR outside the bank.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  AXIL_IF.Slave                          s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_LSB    = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(NUM_REGS);
  localparam int TOP_LSB    = IDX_LSB + IDX_W;

  logic                  ready_en_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  bvalid_q;
  axil_resp_t            bresp_q;
  logic                  rvalid_q;
  axil_resp_t            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, do_write;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0] wr_data_d;

  // Readies depend only on flops, so no input valid reaches an output combinationally.
  assign s_axil.awready = ready_en_q & ~aw_held_q;
  assign s_axil.wready  = ready_en_q & ~w_held_q;
  assign s_axil.arready = ready_en_q & ~rvalid_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;
  assign wr_pulse_o     = wr_pulse_q;

  assign aw_hs    = s_axil.awvalid & s_axil.awready;
  assign w_hs     = s_axil.wvalid & s_axil.wready;
  assign ar_hs    = s_axil.arvalid & s_axil.arready;
  // A new combine waits until the previous B response has been taken.
  assign do_write = aw_held_q & w_held_q & ~bvalid_q;

  assign wr_idx      = awaddr_q[IDX_LSB +: IDX_W];
  assign rd_idx      = s_axil.araddr[IDX_LSB +: IDX_W];
  assign wr_in_range = ((awaddr_q >> TOP_LSB) == '0);
  assign rd_in_range = ((s_axil.araddr >> TOP_LSB) == '0);
  assign wr_data_d   = DATA_WIDTH'(strb_merge(64'(regs_q[wr_idx]), 64'(wdata_q), 8'(wstrb_q)));

  // Sub-word address bits and protection attributes carry no meaning for this bank.
  logic unused_ok;
  assign unused_ok = ^{s_axil.awprot, s_axil.arprot,
                       awaddr_q[IDX_LSB-1:0], s_axil.araddr[IDX_LSB-1:0]};

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end

  // Readies come up on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  // Write path: capture AW and W independently, combine once both are held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VALUE;
    end else begin
      wr_pulse_q <= '0;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s_axil.awaddr;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axil.wdata;
        wstrb_q  <= s_axil.wstrb;
      end
      if (bvalid_q && s_axil.bready) bvalid_q <= 1'b0;
      if (do_write) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        if (wr_in_range) begin
          regs_q[wr_idx]     <= wr_data_d;
          wr_pulse_q[wr_idx] <= 1'b1;
          bresp_q            <= OKAY;
        end else begin
          bresp_q <= SLVERR;
        end
      end
    end
  end

  // Read path: sample the register on AR; non-blocking update means a same-cycle write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else begin
      if (rvalid_q && s_axil.rready) rvalid_q <= 1'b0;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        if (rd_in_range) begin
          rdata_q <= regs_q[rd_idx];
          rresp_q <= OKAY;
        end else begin
          rdata_q <= '0;
          rresp_q <= SLVERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave with hand-computed expectations.
module tb_axil_reg_slave;
  import axil_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] regs;
  logic [15:0]  pulse;
  logic [31:0]  exp_regs [16];
  int           n_checks = 0;
  int           n_err = 0;

  AXIL_IF #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .RESET_VALUE(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axil     (bus),
    .regs_o     (regs),
    .wr_pulse_o (pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 16; k++) chk($sformatf("%s reg%0d", tag, k), regs[k*32 +: 32], exp_regs[k]);
  endtask

  // AW and W in the same cycle, then B taken one cycle after it appears.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
    bus.awvalid = 1'b1; bus.awaddr = a;
    bus.wvalid  = 1'b1; bus.wdata  = d; bus.wstrb = s;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk({tag, " awready held"}, bus.awready, 0);
    chk({tag, " bvalid early"}, bus.bvalid, 0);
    tick();
    chk({tag, " bvalid"}, bus.bvalid, 1);
    chk({tag, " bresp"}, bus.bresp, exp_resp);
    chk({tag, " pulse"}, pulse, exp_pulse);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk({tag, " bvalid drop"}, bus.bvalid, 0);
    chk({tag, " pulse drop"}, pulse, 0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    bus.arvalid = 1'b1; bus.araddr = a;
    tick();
    bus.arvalid = 1'b0;
    chk({tag, " rvalid"}, bus.rvalid, 1);
    chk({tag, " rdata"}, bus.rdata, exp_data);
    chk({tag, " rresp"}, bus.rresp, exp_resp);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk({tag, " rvalid drop"}, bus.rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 16; k++) exp_regs[k] = 32'h0;
    bus.awaddr = '0; bus.awprot = PROT_DEFAULT; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = PROT_PRIV; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // reset state
    #2;
    chk("rst awready", bus.awready, 0);
    chk("rst arready", bus.arready, 0);
    chk("rst bvalid", bus.bvalid, 0);
    chk("rst rvalid", bus.rvalid, 0);
    check_regs("rst");
    tick(); tick();
    rst_n = 1'b1;
    chk("rel awready", bus.awready, 0);
    tick();
    chk("rel awready up", bus.awready, 1);
    chk("rel wready up", bus.wready, 1);
    chk("rel arready up", bus.arready, 1);

    // full-word write and read back
    do_write("t1", 32'h04, 32'hDEADBEEF, 4'hF, 2'(OKAY), 16'h0002);
    exp_regs[1] = 32'hDEADBEEF;
    check_regs("t1");
    do_read("t1 rd", 32'h04, 32'hDEADBEEF, 2'(OKAY));

    // W two cycles ahead of AW, partial strobe
    do_write("t2 pre", 32'h08, 32'hAAAAAAAA, 4'hF, 2'(OKAY), 16'h0004);
    bus.wvalid = 1'b1; bus.wdata = 32'h12345678; bus.wstrb = 4'h3;
    tick();
    bus.wvalid = 1'b0;
    chk("t2 wready held", bus.wready, 0);
    chk("t2 bvalid w only", bus.bvalid, 0);
    tick();
    chk("t2 bvalid idle", bus.bvalid, 0);
    bus.awvalid = 1'b1; bus.awaddr = 32'h08;
    tick();
    bus.awvalid = 1'b0;
    chk("t2 bvalid early", bus.bvalid, 0);
    tick();
    chk("t2 bvalid", bus.bvalid, 1);
    chk("t2 bresp", bus.bresp, OKAY);
    chk("t2 pulse", pulse, 16'h0004);
    exp_regs[2] = 32'hAAAA5678;
    chk("t2 reg2", regs[2*32 +: 32], exp_regs[2]);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("t2 bvalid drop", bus.bvalid, 0);
    tick();
    chk("t2 single B", bus.bvalid, 0);

    // out of range
    do_write("t3", 32'h40, 32'hFFFFFFFF, 4'hF, 2'(SLVERR), 16'h0000);
    check_regs("t3");
    do_read("t3 rd", 32'h40, 32'h0, 2'(SLVERR));

    // zero strobe still pulses; unaligned read ignores low bits
    do_write("zs", 32'h04, 32'h00000000, 4'h0, 2'(OKAY), 16'h0002);
    do_read("zs rd", 32'h05, 32'hDEADBEEF, 2'(OKAY));

    // bready held low while a second write is accepted
    bus.awvalid = 1'b1; bus.awaddr = 32'h10;
    bus.wvalid = 1'b1; bus.wdata = 32'h11111111; bus.wstrb = 4'hF;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    chk("t4 bvalid", bus.bvalid, 1);
    chk("t4 pulse", pulse, 16'h0010);
    exp_regs[4] = 32'h11111111;
    bus.awvalid = 1'b1; bus.awaddr = 32'h14;
    bus.wvalid = 1'b1; bus.wdata = 32'h22222222; bus.wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      end
      chk($sformatf("t4 hold bvalid %0d", i), bus.bvalid, 1);
      chk($sformatf("t4 hold bresp %0d", i), bus.bresp, OKAY);
    end
    chk("t4 awready held", bus.awready, 0);
    chk("t4 wready held", bus.wready, 0);
    chk("t4 reg5 pending", regs[5*32 +: 32], exp_regs[5]);
    chk("t4 pulse idle", pulse, 0);
    bus.bready = 1'b1;
    tick();
    chk("t4 B taken", bus.bvalid, 0);
    tick();
    chk("t4 second B", bus.bvalid, 1);
    chk("t4 second pulse", pulse, 16'h0020);
    exp_regs[5] = 32'h22222222;
    tick();
    bus.bready = 1'b0;
    chk("t4 second B drop", bus.bvalid, 0);
    check_regs("t4");

    // read colliding with the completing write
    bus.awvalid = 1'b1; bus.awaddr = 32'h0C;
    bus.wvalid = 1'b1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = 32'h0C;
    tick();
    bus.arvalid = 1'b0;
    chk("t5 rvalid", bus.rvalid, 1);
    chk("t5 rdata old", bus.rdata, 32'h0);
    chk("t5 bvalid", bus.bvalid, 1);
    chk("t5 pulse", pulse, 16'h0008);
    exp_regs[3] = 32'hCAFEF00D;
    chk("t5 reg3", regs[3*32 +: 32], exp_regs[3]);
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    chk("t5 bvalid drop", bus.bvalid, 0);
    chk("t5 rvalid drop", bus.rvalid, 0);
    do_read("t5 rd", 32'h0C, 32'hCAFEF00D, 2'(OKAY));

    // reset mid-transaction
    bus.awvalid = 1'b1; bus.awaddr = 32'h18;
    bus.arvalid = 1'b1; bus.araddr = 32'h04;
    tick();
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    chk("t6 rvalid pending", bus.rvalid, 1);
    chk("t6 rdata pending", bus.rdata, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 awready", bus.awready, 0);
    chk("t6 wready", bus.wready, 0);
    chk("t6 arready", bus.arready, 0);
    chk("t6 bvalid", bus.bvalid, 0);
    chk("t6 rvalid", bus.rvalid, 0);
    chk("t6 rdata", bus.rdata, 0);
    chk("t6 rresp", bus.rresp, OKAY);
    chk("t6 bresp", bus.bresp, OKAY);
    chk("t6 pulse", pulse, 0);
    for (int k = 0; k < 16; k++) exp_regs[k] = 32'h0;
    check_regs("t6");
    tick();
    rst_n = 1'b1;
    chk("t6 arready rel", bus.arready, 0);
    tick();
    chk("t6 awready up", bus.awready, 1);
    chk("t6 arready up", bus.arready, 1);
    bus.wvalid = 1'b1; bus.wdata = 32'h77777777; bus.wstrb = 4'hF;
    tick();
    bus.wvalid = 1'b0;
    tick();
    chk("t6 no stale aw", bus.bvalid, 0);
    tick();
    chk("t6 no stale aw 2", bus.bvalid, 0);
    bus.awvalid = 1'b1; bus.awaddr = 32'h00;
    tick();
    bus.awvalid = 1'b0;
    tick();
    chk("t6 bvalid", bus.bvalid, 1);
    chk("t6 pulse0", pulse, 16'h0001);
    exp_regs[0] = 32'h77777777;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check_regs("t6 end");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
# axil_reg_slave

AXI4-Lite responder exposing a bank of NUM_REGS read/write control registers on the AXIL_IF Slave modport. Captures write address and write data independently, merges bytes under wstrb, answers reads with one-cycle latency, and returns SLVERR for accesses beyond the bank. Sits behind an interconnect or directly on a CPU master. Register contents drive fabric logic through a flat output vector plus per-register write pulses.

## Interface
- ADDR_WIDTH, 32, address width; must match the connected AXIL_IF.
- DATA_WIDTH, 32, data width; 32 or 64; STRB_WIDTH = DATA_WIDTH/8.
- NUM_REGS, 16, register count; power of two, 2..256.
- RESET_VALUE, 0, DATA_WIDTH reset value applied to every register.
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous, active-low reset.
- s_axil  AXIL_IF.Slave  —  AXI4-Lite responder port.
- regs_o  output  NUM_REGS*DATA_WIDTH  register contents; register k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse_o  output  NUM_REGS  one-cycle pulse on the cycle after register k is written by an accepted write (any strobe, including all-zero).

## Operation
- Word index = addr[IDX_LSB +: log2(NUM_REGS)], IDX_LSB = log2(STRB_WIDTH); low IDX_LSB bits ignored (no alignment error).
- In range: addr < NUM_REGS*STRB_WIDTH, i.e., all bits above the index field are zero; otherwise SLVERR.
- awprot/arprot accepted and ignored.
- Write path: flags aw_held, w_held. AW handshake sets aw_held and latches awaddr; W handshake sets w_held and latches wdata/wstrb. Either order, or same cycle.
- When both held and bvalid low: perform the write (byte i updated iff wstrb[i]), set bvalid, bresp OKAY or SLVERR; both flags clear. Out-of-range writes modify nothing and produce no pulse.
- bvalid held until bready; bresp stable while bvalid.
- Read path: AR handshake latches rdata = register value (0 if out of range) and rresp; rvalid set next cycle, held until rready; rdata/rresp stable while rvalid.
- Read and write paths fully independent; read and write to the same register in the same cycle: read returns the pre-write value.

## Timing
- Reset (async assert): all registers = RESET_VALUE; awready, wready, arready, bvalid, rvalid = 0; bresp = rresp = OKAY; rdata = 0; wr_pulse_o = 0; held flags cleared. Any in-flight transaction is dropped, no response issued.
- Readies are registered flops: 0 during reset, 1 from the first clk edge after rst_n deassertion.
- awready = ready_en & !aw_held; wready = ready_en & !w_held; arready = ready_en & !rvalid.
- AW and W handshakes both at edge T: register updated and bvalid high after edge T+1; wr_pulse_o high in the same cycle as bvalid.
- Next AW/W accepted the cycle after the combine (held flags cleared at T+1); a new combine waits while bvalid is high. Max throughput with bready tied high: one write per 2 cycles.
- AR at edge T: rvalid high after edge T; next AR accepted the cycle after R handshake. Max throughput: one read per 2 cycles.
- No combinational path from any input valid/ready to any output.

## Structure
- Shared package axil_pkg: axil_resp_t {OKAY, EXOKAY, SLVERR, DECERR} and axil_prot_t enums (moved out of AXIL_IF so the interface and all modules import one definition), plus function strb_merge(old, new, strb).
- Single module; no sub-module. Write-combine and read-response logic as separate always_ff blocks.

## Test plan
- Write 0xDEADBEEF to 0x04 (AW and W same cycle, wstrb=0xF) -> bresp OKAY, bvalid one cycle later, wr_pulse_o[1] single pulse, read 0x04 returns 0xDEADBEEF.
- W two cycles before AW to 0x08 with wstrb=0x3, data 0x1234_5678, prior value 0xAAAA_AAAA -> register = 0xAAAA_5678, single B response.
- Write and read 0x40 with NUM_REGS=16 -> both SLVERR, rdata 0, no register or wr_pulse_o change.
- bready held low 5 cycles after a write -> bvalid/bresp stable; second AW and W accepted but not combined until B handshake; second B follows.
- Same-cycle AR and completing write to 0x0C -> rdata returns old value, subsequent read returns new.
- Assert rst_n mid-transaction (AW held, rvalid pending) -> all outputs at reset values immediately, registers = RESET_VALUE, readies return one cycle after release.
